// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner
// Purpose  : Multi-channel push-button conditioner. Each channel synchronises
//            a raw key pin, normalises polarity, debounces it and produces a
//            debounced level, press/release pulses and a typematic
//            auto-repeat pulse stream.
// Ports    : clk_i      - system clock, rising-edge active
//            rst_i      - asynchronous active-high reset
//            keys_i     - raw key pins [N_KEYS-1:0], polarity per ACTIVE_LOW
//            level_o    - debounced pressed state (1 = pressed)
//            press_o    - one-cycle pulse per accepted press
//            release_o  - one-cycle pulse per accepted release
//            repeat_o   - pulse on press, then auto-repeat pulses while held
// Revision : 1.0 - initial release
// ============================================================================
module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_KEYS-1:0] keys_i,
  output logic [N_KEYS-1:0] level_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] repeat_o
);

  // Debounce counter tops out at DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  // Repeat counter tops out at max(REPEAT_DELAY, REPEAT_PERIOD)-1.
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

  // Level a synchroniser flop holds while no key is pressed.
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_WAIT_NEXT  = 2'd2
  } rpt_state_e;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    logic            sync1_q, sync2_q;
    logic            sample;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            rpt_q, rpt_d;
    rpt_state_e      st_q, st_d;
    logic [RC_W-1:0] rc_q, rc_d;

    // Normalise so that 1 always means pressed.
    assign sample = REL_LVL ? ~sync2_q : sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync1_q  <= REL_LVL;
        sync2_q  <= REL_LVL;
        db_cnt_q <= '0;
        level_q  <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        rpt_q    <= 1'b0;
        st_q     <= ST_IDLE;
        rc_q     <= '0;
      end else begin
        sync1_q  <= keys_i[gi];
        sync2_q  <= sync1_q;
        db_cnt_q <= db_cnt_d;
        level_q  <= level_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
        rpt_q    <= rpt_d;
        st_q     <= st_d;
        rc_q     <= rc_d;
      end
    end

    // Debounce: count consecutive cycles of disagreement; any agreement
    // restarts the count, so only an unbroken run is accepted.
    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      if (sample != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d = sample;
          press_d = sample;
          rel_d   = ~sample;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
    end

    // Repeat FSM. It reacts to the same-cycle press/release decisions so
    // the first repeat pulse lines up with press_o, and release takes
    // priority over a repeat falling due on the same edge.
    always_comb begin
      st_d  = st_q;
      rc_d  = rc_q;
      rpt_d = 1'b0;
      if (rel_d) begin
        st_d = ST_IDLE;
        rc_d = '0;
      end else if (press_d) begin
        rpt_d = 1'b1;
        rc_d  = '0;
        st_d  = (REPEAT_DELAY == 0) ? ST_IDLE : ST_WAIT_FIRST;
      end else begin
        case (st_q)
          ST_WAIT_FIRST: begin
            if (rc_q == RD_LAST) begin
              rpt_d = 1'b1;
              rc_d  = '0;
              st_d  = ST_WAIT_NEXT;
            end else begin
              rc_d = rc_q + RC_ONE;
            end
          end
          ST_WAIT_NEXT: begin
            if (rc_q == RP_LAST) begin
              rpt_d = 1'b1;
              rc_d  = '0;
            end else begin
              rc_d = rc_q + RC_ONE;
            end
          end
          default: begin
            st_d = ST_IDLE;
            rc_d = '0;
          end
        endcase
      end
    end

    assign level_o[gi]   = level_q;
    assign press_o[gi]   = press_q;
    assign release_o[gi] = rel_q;
    assign repeat_o[gi]  = rpt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_conditioner
// Purpose  : Self-checking bench for key_conditioner. Two instances: the
//            active-low build and an active-high build. Stimulus pushes the
//            hand-computed output events into a scoreboard; a monitor on the
//            falling clock edge matches every observed pulse/level edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

  localparam int KP = 0, KR = 1, KT = 2, KRISE = 3, KFALL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] keys_a, keys_p;
  logic [2:0] lvl_a, prs_a, rel_a, rpt_a;
  logic [2:0] lvl_p, prs_p, rel_p, rpt_p;
  int         edge_n = 0;
  int         tests = 0;
  int         fails = 0;
  logic [2:0] prev_lvl [2];

  typedef struct { int d; int cyc; int ch; int kind; } ev_t;
  ev_t exp_q[$];

  key_conditioner #(.N_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
                    .REPEAT_PERIOD(3), .ACTIVE_LOW(1)) dut (
    .clk_i(clk), .rst_i(rst), .keys_i(keys_a), .level_o(lvl_a),
    .press_o(prs_a), .release_o(rel_a), .repeat_o(rpt_a));

  key_conditioner #(.N_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
                    .REPEAT_PERIOD(3), .ACTIVE_LOW(0)) dut_p (
    .clk_i(clk), .rst_i(rst), .keys_i(keys_p), .level_o(lvl_p),
    .press_o(prs_p), .release_o(rel_p), .repeat_o(rpt_p));

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic push(input int d, input int cyc, input int ch, input int kind);
    ev_t e;
    e.d = d; e.cyc = cyc; e.ch = ch; e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Key accepted at edge a, release accepted at edge r.
  task automatic exp_hold(input int d, input int ch, input int a, input int r);
    push(d, a, ch, KRISE);
    push(d, a, ch, KP);
    push(d, a, ch, KT);
    for (int t = a + 10; t < r; t += 3) push(d, t, ch, KT);
    push(d, r, ch, KFALL);
    push(d, r, ch, KR);
  endtask

  task automatic match(input int d, input int ch, input int kind);
    int idx;
    idx = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (idx < 0 && exp_q[k].d == d && exp_q[k].ch == ch &&
          exp_q[k].kind == kind && exp_q[k].cyc == edge_n) idx = k;
    tests++;
    if (idx >= 0) exp_q.delete(idx);
    else begin
      fails++;
      $display("FAIL unexpected_event dut=%0d ch=%0d kind=%0d at edge %0d (actual 1, required 0)",
               d, ch, kind, edge_n);
    end
  endtask

  task automatic scan(input int d, input logic [2:0] l, input logic [2:0] p,
                      input logic [2:0] r, input logic [2:0] t);
    for (int ch = 0; ch < 3; ch++) begin
      if (p[ch]) match(d, ch, KP);
      if (r[ch]) match(d, ch, KR);
      if (t[ch]) match(d, ch, KT);
      if (l[ch] && !prev_lvl[d][ch]) match(d, ch, KRISE);
      if (!l[ch] && prev_lvl[d][ch]) match(d, ch, KFALL);
    end
    prev_lvl[d] = l;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_lvl[0] = 3'b000;
      prev_lvl[1] = 3'b000;
    end else begin
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
        if (exp_q[k].cyc < edge_n) begin
          tests++;
          fails++;
          $display("FAIL missing_event dut=%0d ch=%0d kind=%0d due edge %0d (actual 0, required 1)",
                   exp_q[k].d, exp_q[k].ch, exp_q[k].kind, exp_q[k].cyc);
          exp_q.delete(k);
        end
      end
      scan(0, lvl_a, prs_a, rel_a, rpt_a);
      scan(1, lvl_p, prs_p, rel_p, rpt_p);
    end
  end

  // ---------------- direct checks ----------------
  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lvl_a"}, lvl_a, 3'b000);
    chk({tag, "_prs_a"}, prs_a, 3'b000);
    chk({tag, "_rel_a"}, rel_a, 3'b000);
    chk({tag, "_rpt_a"}, rpt_a, 3'b000);
    chk({tag, "_lvl_p"}, lvl_p, 3'b000);
    chk({tag, "_prs_p"}, prs_p, 3'b000);
    chk({tag, "_rel_p"}, rel_p, 3'b000);
    chk({tag, "_rpt_p"}, rpt_p, 3'b000);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, a, m;
    prev_lvl[0] = 3'b000;
    prev_lvl[1] = 3'b000;
    keys_a = 3'b111;
    keys_p = 3'b000;
    rst = 1'b1;
    step(3);
    chk_all_zero("reset");
    rst = 1'b0;
    step(2);
    chk_all_zero("post_reset");

    // Clean press of key 0, released before first auto-repeat is due.
    n = edge_n;
    keys_a[0] = 1'b0;
    exp_hold(0, 0, n + 6, n + 14);
    step(8);
    keys_a[0] = 1'b1;
    step(10);

    // Three-cycle glitch on key 1: no activity expected.
    keys_a[1] = 1'b0;
    step(3);
    keys_a[1] = 1'b1;
    step(10);
    chk("glitch_level", lvl_a, 3'b000);

    // Auto-repeat on key 2, held 30 cycles past acceptance.
    n = edge_n;
    a = n + 6;
    keys_a[2] = 1'b0;
    exp_hold(0, 2, a, a + 36);
    step(36);
    keys_a[2] = 1'b1;
    step(10);

    // Keys 0 and 2 together; key 0 lifted after 2 cycles. Key 2 release
    // lands on the edge a second repeat would be due (a+13).
    n = edge_n;
    a = n + 6;
    keys_a = 3'b010;
    exp_hold(0, 2, a, a + 13);
    step(2);
    keys_a[0] = 1'b1;
    step(11);
    keys_a[2] = 1'b1;
    step(10);

    // Reset while key 1 is in the periodic-repeat phase.
    n = edge_n;
    a = n + 6;
    keys_a[1] = 1'b0;
    push(0, a, 1, KRISE);
    push(0, a, 1, KP);
    push(0, a, 1, KT);
    push(0, a + 10, 1, KT);
    push(0, a + 13, 1, KT);
    step(20);
    chk("pre_reset_level", lvl_a, 3'b010);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    step(2);
    m = edge_n;
    rst = 1'b0;
    exp_hold(0, 1, m + 6, m + 14);
    step(8);
    keys_a[1] = 1'b1;
    step(10);

    // Active-high build: key 0 held 20 cycles past acceptance.
    chk("pol_idle_level", lvl_p, 3'b000);
    n = edge_n;
    a = n + 6;
    keys_p = 3'b001;
    exp_hold(1, 0, a, a + 26);
    step(7);
    chk("pol_level", lvl_p, 3'b001);
    step(19);
    keys_p = 3'b000;
    step(10);

    step(5);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
